win3x3_ctrl: RTL and testbench

- Frame/line sequencer for the 3x3 window generator: line-buffer shift IP plus 9-register matrix fed from one 8-bit pixel stream.
- Tracks the pixel position of the incoming stream and gates the line-buffer clock enable.
- Flags when the matrix holds a fully valid 3x3 neighbourhood and reports centre coordinates.
- Sits between the camera capture stream and the filter stages (Sobel, median, ...) that consume the matrix.

---
 rtl/win3x3_ctrl.sv | 149 ++++++++++++++
 tb/tb_win3x3_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/win3x3_ctrl.sv
// Frame/line sequencer for the 3x3 window generator: tracks stream position,
// gates the line-buffer shift and flags when the 9-register matrix holds a full window.
module win3x3_ctrl #(
   parameter int H_ACTIVE = 640,
   parameter int V_ACTIVE = 480,
   parameter int CNT_W    = 11
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             vsync,
   input  logic             din_vld,
   output logic             shift_en,
   output logic [CNT_W-1:0] col_cnt,
   output logic [CNT_W-1:0] row_cnt,
   output logic             win_vld,
   output logic [CNT_W-1:0] win_x,
   output logic [CNT_W-1:0] win_y,
   output logic             frame_done,
   output logic             line_err,
   output logic             frame_err,
   output logic [1:0]       state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(H_ACTIVE - 1);
   localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(V_ACTIVE - 1);
   localparam logic [CNT_W-1:0] MIN_POS  = CNT_W'(2);

   state_t           state;
   state_t           state_nxt;
   logic             vsync_d;
   logic             vs_rise;
   logic [1:0]       fill;
   logic             accept;
   logic             last_pix;
   logic [CNT_W-1:0] pix_col;
   logic [CNT_W-1:0] pix_row;
   logic [1:0]       pix_fill;
   logic             win_hit;

   // Handshake: a pixel is taken on a rising edge when shift_en is high; there
   // is no backpressure, the stream owns din_vld and this block only observes it.
   assign vs_rise   = vsync & ~vsync_d;
   assign accept    = (state == ACTIVE) && din_vld;
   assign shift_en  = accept;
   assign state_dbg = state;

   // A vsync rise mid-frame restarts the frame, so the same-cycle pixel sees (0,0).
   assign pix_col  = vs_rise ? '0 : col_cnt;
   assign pix_row  = vs_rise ? '0 : row_cnt;
   assign pix_fill = vs_rise ? 2'd0 : fill;

   assign last_pix = accept && (pix_col == COL_LAST) && (pix_row == ROW_LAST);
   assign win_hit  = accept && (pix_col >= MIN_POS) && (pix_row >= MIN_POS)
                     && (pix_fill == 2'd2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         vsync_d <= 1'b0;
      end else begin
         state   <= state_nxt;
         vsync_d <= vsync;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (vs_rise)  state_nxt = ACTIVE;
         ACTIVE:  if (last_pix) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Position counters hold their final values in DONE/IDLE until the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_cnt <= '0;
         row_cnt <= '0;
      end else if (state == IDLE) begin
         if (vs_rise) begin
            col_cnt <= '0;
            row_cnt <= '0;
         end
      end else if (state == ACTIVE) begin
         if (accept) begin
            if (!last_pix) begin
               if (pix_col == COL_LAST) begin
                  col_cnt <= '0;
                  row_cnt <= pix_row + CNT_W'(1);
               end else begin
                  col_cnt <= pix_col + CNT_W'(1);
                  row_cnt <= pix_row;
               end
            end
         end else if (vs_rise) begin
            col_cnt <= '0;
            row_cnt <= '0;
         end
      end
   end

   // Matrix registers shift every clock, so any gap invalidates the run of columns.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fill <= 2'd0;
      end else if (state == IDLE) begin
         if (vs_rise) fill <= 2'd0;
      end else if (state == ACTIVE) begin
         if (!din_vld)              fill <= 2'd0;
         else if (pix_fill == 2'd2) fill <= 2'd2;
         else                       fill <= pix_fill + 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_vld <= 1'b0;
         win_x   <= '0;
         win_y   <= '0;
      end else begin
         win_vld <= win_hit;
         if (win_hit) begin
            win_x <= pix_col - CNT_W'(1);
            win_y <= pix_row - CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done <= 1'b0;
         line_err   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= last_pix;
         if ((state == ACTIVE) && !din_vld && (col_cnt != '0)) line_err <= 1'b1;
         if ((state == ACTIVE) && vs_rise) frame_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_win3x3_ctrl.sv
// Bench for win3x3_ctrl: directed frames plus random traffic checked against a
// pixel-index reference model of the frame/window rules.
module tb_win3x3_ctrl;

   localparam int H  = 8;
   localparam int V  = 4;
   localparam int CW = 11;

   logic          clk;
   logic          rst_n;
   logic          vsync;
   logic          din_vld;
   logic          shift_en;
   logic [CW-1:0] col_cnt;
   logic [CW-1:0] row_cnt;
   logic          win_vld;
   logic [CW-1:0] win_x;
   logic [CW-1:0] win_y;
   logic          frame_done;
   logic          line_err;
   logic          frame_err;
   logic [1:0]    state_dbg;

   int checks = 0;
   int errors = 0;

   // reference model: frame position as a linear pixel index plus run length
   bit m_active, m_done, m_vs_d;
   int m_pix, m_run;
   bit exp_shift, exp_win, exp_done, exp_lerr, exp_ferr;
   int exp_wx, exp_wy;

   // per-test observations of DUT behaviour
   int win_seen, done_seen, first_wx, first_wy, last_wx, last_wy;

   win3x3_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .CNT_W(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .vsync      (vsync),
      .din_vld    (din_vld),
      .shift_en   (shift_en),
      .col_cnt    (col_cnt),
      .row_cnt    (row_cnt),
      .win_vld    (win_vld),
      .win_x      (win_x),
      .win_y      (win_y),
      .frame_done (frame_done),
      .line_err   (line_err),
      .frame_err  (frame_err),
      .state_dbg  (state_dbg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_done = 0; m_vs_d = 0; m_pix = 0; m_run = 0;
      exp_shift = 0; exp_win = 0; exp_done = 0; exp_lerr = 0; exp_ferr = 0;
      exp_wx = 0; exp_wy = 0;
   endtask

   task automatic model_step(input logic vs, input logic dv);
      bit rise;
      int col, row;
      rise = vs && !m_vs_d;
      m_vs_d = vs;
      exp_shift = m_active && dv;
      exp_win = 0;
      exp_done = 0;
      if (m_active) begin
         if (!dv && (m_pix % H) != 0) exp_lerr = 1;
         if (rise) begin
            exp_ferr = 1; m_pix = 0; m_run = 0;
         end
         if (dv) begin
            col = m_pix % H;
            row = m_pix / H;
            if (col >= 2 && row >= 2 && m_run >= 2) begin
               exp_win = 1; exp_wx = col - 1; exp_wy = row - 1;
            end
            m_run++;
            if (m_pix == H * V - 1) begin
               m_active = 0; m_done = 1; exp_done = 1;
            end else begin
               m_pix++;
            end
         end else begin
            m_run = 0;
         end
      end else if (m_done) begin
         m_done = 0;
      end else if (rise) begin
         m_active = 1; m_pix = 0; m_run = 0;
      end
   endtask

   task automatic check_regs();
      chk("col_cnt", 32'(col_cnt), 32'(m_pix % H));
      chk("row_cnt", 32'(row_cnt), 32'(m_pix / H));
      chk("win_vld", 32'(win_vld), 32'(exp_win));
      chk("win_x", 32'(win_x), 32'(exp_wx));
      chk("win_y", 32'(win_y), 32'(exp_wy));
      chk("frame_done", 32'(frame_done), 32'(exp_done));
      chk("line_err", 32'(line_err), 32'(exp_lerr));
      chk("frame_err", 32'(frame_err), 32'(exp_ferr));
      if (win_vld === 1'b1) begin
         if (win_seen == 0) begin
            first_wx = int'(win_x); first_wy = int'(win_y);
         end
         last_wx = int'(win_x); last_wy = int'(win_y);
         win_seen++;
      end
      if (frame_done === 1'b1) done_seen++;
   endtask

   task automatic step(input logic vs, input logic dv);
      @(negedge clk);
      vsync = vs;
      din_vld = dv;
      #1;
      model_step(vs, dv);
      chk("shift_en", 32'(shift_en), 32'(exp_shift));
      @(posedge clk);
      #1;
      check_regs();
   endtask

   task automatic clear_obs();
      win_seen = 0; done_seen = 0;
      first_wx = -1; first_wy = -1; last_wx = -1; last_wy = -1;
   endtask

   task automatic pixels(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_shift_en"}, 32'(shift_en), 32'd0);
      chk({tag, "_col"}, 32'(col_cnt), 32'd0);
      chk({tag, "_row"}, 32'(row_cnt), 32'd0);
      chk({tag, "_win_vld"}, 32'(win_vld), 32'd0);
      chk({tag, "_win_x"}, 32'(win_x), 32'd0);
      chk({tag, "_win_y"}, 32'(win_y), 32'd0);
      chk({tag, "_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_lerr"}, 32'(line_err), 32'd0);
      chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
      chk({tag, "_state_idle"}, 32'(state_dbg), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      vsync = 1'b0;
      din_vld = 1'b0;
      model_reset();
      clear_obs();
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // stream without vsync is ignored
      clear_obs();
      pixels(6);
      chk("novsync_windows", 32'(win_seen), 32'd0);

      // contiguous frame
      clear_obs();
      step(1'b1, 1'b0);
      pixels(H * V);
      idle(3);
      chk("A_win_count", 32'(win_seen), 32'd12);
      chk("A_first_x", 32'(first_wx), 32'd1);
      chk("A_first_y", 32'(first_wy), 32'd1);
      chk("A_last_x", 32'(last_wx), 32'd6);
      chk("A_last_y", 32'(last_wy), 32'd2);
      chk("A_done_count", 32'(done_seen), 32'd1);

      // one idle cycle between lines is legal blanking
      clear_obs();
      step(1'b1, 1'b0);
      for (int r = 0; r < V; r++) begin
         pixels(H);
         step(1'b0, 1'b0);
      end
      idle(2);
      chk("B_win_count", 32'(win_seen), 32'd12);
      chk("B_line_err", 32'(line_err), 32'd0);

      // gap inside row 2 after column 4
      clear_obs();
      step(1'b1, 1'b0);
      pixels(2 * H + 5);
      step(1'b0, 1'b0);
      pixels(3 + H);
      idle(2);
      chk("C_win_count", 32'(win_seen), 32'd10);
      chk("C_line_err", 32'(line_err), 32'd1);
      chk("C_frame_err", 32'(frame_err), 32'd0);

      // vsync rises again at pixel (3,1): restart, frame still completes
      clear_obs();
      step(1'b1, 1'b0);
      pixels(H + 3);
      step(1'b1, 1'b1);
      chk("D_col_after_restart", 32'(col_cnt), 32'd1);
      chk("D_row_after_restart", 32'(row_cnt), 32'd0);
      pixels(H * V - 1);
      idle(2);
      chk("D_frame_err", 32'(frame_err), 32'd1);
      chk("D_done_count", 32'(done_seen), 32'd1);
      chk("D_win_count", 32'(win_seen), 32'd12);

      // random traffic with occasional vsync pulses
      for (int i = 0; i < 600; i++) begin
         step(($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0,
              ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0);
      end

      // asynchronous reset in the middle of row 2
      idle(2);
      step(1'b1, 1'b0);
      pixels(2 * H + 3);
      @(negedge clk);
      din_vld = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async_rst");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      clear_obs();
      pixels(8);
      chk("post_rst_windows", 32'(win_seen), 32'd0);
      step(1'b1, 1'b0);
      pixels(H * V);
      idle(2);
      chk("post_rst_win_count", 32'(win_seen), 32'd12);
      chk("post_rst_done_count", 32'(done_seen), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
